// File: rtl/store_commit_queue.sv
// store_commit_queue: two-level store buffer. Translated stores wait in a
// speculative FIFO until committed. Committed stores wait in a commit FIFO that
// drains to the data cache one request at a time over req/gnt.
// Latency: a commit in cycle N is in the commit FIFO at N+1. The earliest req_o is at N+2.
// Backpressure: ready_o and commit_ready_o come from registered counts only.
//   The drain holds req_o and its fields stable until gnt_i.
// Ports: push side (valid_i/ready_o, paddr_i, data_i, be_i, data_size_i), commit_i/commit_ready_o,
//   flush_i, stall_st_pending_i, the load hazard check (page_offset_i -> page_offset_matches_o),
//   status outputs (no_st_pending_o, store_buffer_empty_o) and the cache request
//   (req_o, addr_o, wdata_o, be_o, size_o, gnt_i).
// Optional: define STB_FULL_STALL_CNT_EN to add full_stall_cnt_o, a saturating count of
//   push/commit attempts that were refused because a FIFO was full.
module store_commit_queue #(
  parameter int unsigned PLEN         = 56,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_st_pending_i,
  input  logic              valid_i,
  input  logic              valid_without_flush_i,
  output logic              ready_o,
  input  logic [PLEN-1:0]   paddr_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [1:0]        data_size_i,
  input  logic              commit_i,
  output logic              commit_ready_o,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_matches_o,
  output logic              no_st_pending_o,
  output logic              store_buffer_empty_o,
  output logic              req_o,
  output logic [PLEN-1:0]   addr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [1:0]        size_o,
`ifdef STB_FULL_STALL_CNT_EN
  output logic [31:0]       full_stall_cnt_o,
`endif
  input  logic              gnt_i
);
  localparam int unsigned SPW = $clog2(SPEC_DEPTH);
  localparam int unsigned CPW = $clog2(COMMIT_DEPTH);
  localparam logic [SPW:0] SPEC_FULL   = (SPW+1)'(SPEC_DEPTH);
  localparam logic [CPW:0] COMMIT_FULL = (CPW+1)'(COMMIT_DEPTH);

  typedef struct packed {
    logic [PLEN-1:0]   paddr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
    logic [1:0]        size;
  } st_t;

  typedef enum logic {IDLE, REQ} state_t;

  st_t            spec_mem [SPEC_DEPTH];
  logic [SPW-1:0] spec_rd, spec_wr;
  logic [SPW:0]   spec_cnt;
  st_t            commit_mem [COMMIT_DEPTH];
  logic [CPW-1:0] commit_rd, commit_wr, next_idx;
  logic [CPW:0]   commit_cnt;
  st_t            req_q;
  state_t         state, state_nxt;
  logic           push, commit, gnt_pop, has_next, load_next;
  logic [2:0]     unused_po;

  assign unused_po = page_offset_i[2:0];

  assign ready_o        = (spec_cnt != SPEC_FULL);
  assign commit_ready_o = (commit_cnt != COMMIT_FULL);

  // A push in a flush cycle is dropped. A commit in a flush cycle still moves the head first.
  assign push    = valid_i && ready_o && !flush_i;
  assign commit  = commit_i && commit_ready_o && (spec_cnt != '0);
  assign gnt_pop = (state == REQ) && gnt_i;

  // The in-flight store stays at the commit head until it is granted.
  // On a grant, the next candidate is therefore the entry after the head.
  assign has_next  = (state == IDLE) ? (commit_cnt != '0) : (commit_cnt > (CPW+1)'(1));
  assign load_next = !stall_st_pending_i && has_next && ((state == IDLE) || gnt_i);
  assign next_idx  = (state == IDLE) ? commit_rd : commit_rd + 1'b1;

  // Speculative FIFO control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_rd  <= '0;
      spec_wr  <= '0;
      spec_cnt <= '0;
    end else if (flush_i) begin
      spec_rd  <= '0;
      spec_wr  <= '0;
      spec_cnt <= '0;
    end else begin
      if (push)   spec_wr <= spec_wr + 1'b1;
      if (commit) spec_rd <= spec_rd + 1'b1;
      case ({push, commit})
        2'b10:   spec_cnt <= spec_cnt + 1'b1;
        2'b01:   spec_cnt <= spec_cnt - 1'b1;
        default: spec_cnt <= spec_cnt;
      endcase
    end
  end

  // Commit FIFO control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      commit_rd  <= '0;
      commit_wr  <= '0;
      commit_cnt <= '0;
    end else begin
      if (commit)  commit_wr <= commit_wr + 1'b1;
      if (gnt_pop) commit_rd <= commit_rd + 1'b1;
      case ({commit, gnt_pop})
        2'b10:   commit_cnt <= commit_cnt + 1'b1;
        2'b01:   commit_cnt <= commit_cnt - 1'b1;
        default: commit_cnt <= commit_cnt;
      endcase
    end
  end

  // Storage arrays are not reset. Only entries within the counts are ever observed.
  always_ff @(posedge clk_i) begin
    if (push)   spec_mem[spec_wr]     <= '{paddr: paddr_i, data: data_i, be: be_i, size: data_size_i};
    if (commit) commit_mem[commit_wr] <= spec_mem[spec_rd];
  end

  // Drain FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_next) state_nxt = REQ;
      REQ:     if (gnt_i)     state_nxt = load_next ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Drain FSM: outputs
  always_comb begin
    req_o = (state == REQ);
  end

  // Request fields are loaded only when a request starts, so they hold steady until the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i)          req_q <= '0;
    else if (load_next) req_q <= commit_mem[next_idx];
  end

  assign addr_o  = req_q.paddr;
  assign wdata_o = req_q.data;
  assign be_o    = req_q.be;
  assign size_o  = req_q.size;

  assign no_st_pending_o      = (commit_cnt == '0) && (state == IDLE);
  assign store_buffer_empty_o = no_st_pending_o && (spec_cnt == '0);

  // Word-granular (paddr[11:3]) overlap against every pending store and the incoming one.
  // Entry i is valid when its distance from the read pointer is below the count.
  always_comb begin
    logic [SPW-1:0] soff;
    logic [CPW-1:0] coff;
    page_offset_matches_o = 1'b0;
    soff = '0;
    coff = '0;
    for (int i = 0; i < int'(SPEC_DEPTH); i++) begin
      soff = SPW'(i) - spec_rd;
      if (({1'b0, soff} < spec_cnt) && (spec_mem[i].paddr[11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
    for (int i = 0; i < int'(COMMIT_DEPTH); i++) begin
      coff = CPW'(i) - commit_rd;
      if (({1'b0, coff} < commit_cnt) && (commit_mem[i].paddr[11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
    if ((state == REQ) && (req_q.paddr[11:3] == page_offset_i[11:3]))
      page_offset_matches_o = 1'b1;
    if (valid_without_flush_i && (paddr_i[11:3] == page_offset_i[11:3]))
      page_offset_matches_o = 1'b1;
  end

`ifdef STB_FULL_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [1:0]  cnt_inc;
  logic [32:0] cnt_sum;

  assign cnt_inc = {1'b0, valid_i && !ready_o} + {1'b0, commit_i && !commit_ready_o};
  assign cnt_sum = {1'b0, stall_cnt} + {31'b0, cnt_inc};

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt <= '0;
    else       stall_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  assign full_stall_cnt_o = stall_cnt;
`endif

  // Protocol checks on the producer side
  a_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) valid_i |-> ready_o);
  a_commit_when_empty: assert property (@(posedge clk_i) disable iff (rst_i) commit_i |-> (spec_cnt != '0));

endmodule

// File: tb/tb_store_commit_queue.sv
module tb_store_commit_queue;
  typedef struct {
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, stall, valid, vwf, commit, gnt;
  logic [55:0] paddr;
  logic [63:0] data;
  logic [7:0]  be;
  logic [1:0]  size;
  logic [11:0] po;
  logic        ready_o, commit_ready_o, pom_o, no_st_o, sbe_o, req_o;
  logic [55:0] addr_o;
  logic [63:0] wdata_o;
  logic [7:0]  be_o;
  logic [1:0]  size_o;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: the two queues plus a flag for the cache request in flight.
  // The in-flight store is always the commit-queue head.
  ent_t sq[$];
  ent_t cq[$];
  bit   busy;

  always #5 clk = ~clk;

  store_commit_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_st_pending_i(stall),
    .valid_i(valid), .valid_without_flush_i(vwf), .ready_o(ready_o),
    .paddr_i(paddr), .data_i(data), .be_i(be), .data_size_i(size),
    .commit_i(commit), .commit_ready_o(commit_ready_o),
    .page_offset_i(po), .page_offset_matches_o(pom_o),
    .no_st_pending_o(no_st_o), .store_buffer_empty_o(sbe_o),
    .req_o(req_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
    .gnt_i(gnt)
  );

  function automatic bit exp_pom();
    bit m = 0;
    foreach (sq[i]) if (sq[i].paddr[11:3] == po[11:3]) m = 1;
    foreach (cq[i]) if (cq[i].paddr[11:3] == po[11:3]) m = 1;
    if (vwf && paddr[11:3] == po[11:3]) m = 1;
    return m;
  endfunction

  // Advance one clock. The model consumes the inputs the DUT sees at the same edge.
  task automatic cycle();
    ent_t in;
    bit do_push, do_commit;
    @(posedge clk);
    in = '{paddr: paddr, data: data, be: be, size: size};
    if (rst) begin
      sq.delete(); cq.delete(); busy = 0;
    end else begin
      do_push   = valid && sq.size() < 4 && !flush;
      do_commit = commit && cq.size() < 8 && sq.size() > 0;
      if (busy && gnt) begin
        void'(cq.pop_front());
        busy = 0;
      end
      if (!busy) busy = (cq.size() > 0) && !stall;
      if (do_commit) cq.push_back(sq.pop_front());
      if (flush) sq.delete();
      else if (do_push) sq.push_back(in);
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; stall = 0; valid = 0; vwf = 0; commit = 0; gnt = 0;
    paddr = '0; data = '0; be = '0; size = '0; po = '0;
  endtask

  // Drop speculative stores and grant until everything committed has drained.
  task automatic settle();
    idle_inputs();
    flush = 1;
    cycle();
    flush = 0;
    gnt = 1;
    for (int k = 0; k < 30 && (cq.size() > 0 || busy); k++) cycle();
    gnt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_commit_ready: got %b want 1", commit_ready_o); end
    n_checks++; if (no_st_o !== 1'b1) begin n_fail++; $display("FAIL reset_no_st_pending: got %b want 1", no_st_o); end
    n_checks++; if (sbe_o !== 1'b1) begin n_fail++; $display("FAIL reset_sb_empty: got %b want 1", sbe_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req_o); end
    n_checks++; if ({addr_o, wdata_o, be_o, size_o} !== '0) begin n_fail++; $display("FAIL reset_fields: addr %h data %h be %h size %h want 0", addr_o, wdata_o, be_o, size_o); end
    n_checks++; if (pom_o !== 1'b0) begin n_fail++; $display("FAIL reset_pom: got %b want 0", pom_o); end
  endtask

  task automatic test_single();
    idle_inputs();
    valid = 1; paddr = 56'h8000_0010; data = 64'h1122_3344_5566_7788; be = 8'hFF; size = 2'd3;
    cycle();
    valid = 0; commit = 1;
    cycle();
    commit = 0;
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_n1: got %b want 0", req_o); end
    n_checks++; if (no_st_o !== 1'b0) begin n_fail++; $display("FAIL single_no_st_n1: got %b want 0", no_st_o); end
    cycle();
    n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL single_req_n2: got %b want 1", req_o); end
    n_checks++; if (addr_o !== 56'h8000_0010) begin n_fail++; $display("FAIL single_addr: got %h want 80000010", addr_o); end
    n_checks++; if (wdata_o !== 64'h1122_3344_5566_7788 || be_o !== 8'hFF) begin n_fail++; $display("FAIL single_data: got %h/%h", wdata_o, be_o); end
    gnt = 1;
    cycle();
    gnt = 0;
    n_checks++; if (sbe_o !== 1'b1) begin n_fail++; $display("FAIL single_empty_after_gnt: got %b want 1", sbe_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_after_gnt: got %b want 0", req_o); end
  endtask

  task automatic test_full();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      valid = 1; paddr = 56'h100 + 56'(i * 8); be = 8'h0F;
      cycle();
    end
    valid = 0;
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", ready_o); end
    cycle();
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_hold: got %b want 0", ready_o); end
    n_checks++; if (sbe_o !== 1'b0) begin n_fail++; $display("FAIL full_sbe: got %b want 0", sbe_o); end
    commit = 1;
    cycle();
    commit = 0;
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_commit: got %b want 1", ready_o); end
    settle();
    n_checks++; if (sbe_o !== 1'b1) begin n_fail++; $display("FAIL full_settle_empty: got %b want 1", sbe_o); end
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      valid = 1; paddr = 56'h2000 + 56'(i * 8);
      cycle();
    end
    valid = 0; commit = 1; flush = 1;
    cycle();
    commit = 0; flush = 0;
    n_checks++; if (no_st_o !== 1'b0 || sbe_o !== 1'b0) begin n_fail++; $display("FAIL flush_pending: no_st %b sbe %b want 0 0", no_st_o, sbe_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", ready_o); end
    for (int k = 0; k < 5 && !req_o; k++) cycle();
    n_checks++; if (req_o !== 1'b1 || addr_o !== 56'h2000) begin n_fail++; $display("FAIL flush_drain: req %b addr %h want 1 2000", req_o, addr_o); end
    gnt = 1;
    cycle();
    gnt = 0;
    n_checks++; if (sbe_o !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", sbe_o); end
    cycle(); cycle();
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL flush_extra_req: got %b want 0", req_o); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] exp_addr [8];
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      valid = (i < 8);
      paddr = 56'h4_0000 + 56'(i * 64);
      if (i < 8) exp_addr[i] = paddr;
      commit = (i >= 1);
      cycle();
    end
    valid = 0; commit = 0;
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_commit_full: got %b want 0", commit_ready_o); end
    gnt = 1;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (req_o !== 1'b1 || addr_o !== exp_addr[k]) begin
        n_fail++; $display("FAIL b2b_grant%0d: req %b addr %h want 1 %h", k, req_o, addr_o, exp_addr[k]);
      end
      cycle();
    end
    gnt = 0;
    n_checks++; if (req_o !== 1'b0 || sbe_o !== 1'b1) begin n_fail++; $display("FAIL b2b_end: req %b sbe %b want 0 1", req_o, sbe_o); end
  endtask

  task automatic test_page_offset();
    idle_inputs();
    valid = 1; paddr = 56'hAB_0000_1238;
    cycle();
    valid = 0; paddr = '0;
    po = 12'h23C; #1;
    n_checks++; if (pom_o !== 1'b1) begin n_fail++; $display("FAIL pom_spec_hit: got %b want 1", pom_o); end
    po = 12'h240; #1;
    n_checks++; if (pom_o !== 1'b0) begin n_fail++; $display("FAIL pom_spec_miss: got %b want 0", pom_o); end
    commit = 1;
    cycle();
    commit = 0; po = 12'h238; #1;
    n_checks++; if (pom_o !== 1'b1) begin n_fail++; $display("FAIL pom_commit_hit: got %b want 1", pom_o); end
    cycle();
    n_checks++; if (pom_o !== 1'b1 || req_o !== 1'b1) begin n_fail++; $display("FAIL pom_inflight_hit: pom %b req %b want 1 1", pom_o, req_o); end
    po = 12'h240; #1;
    n_checks++; if (pom_o !== 1'b0) begin n_fail++; $display("FAIL pom_inflight_miss: got %b want 0", pom_o); end
    gnt = 1;
    cycle();
    gnt = 0;
    vwf = 1; paddr = 56'h5008; po = 12'h00C; #1;
    n_checks++; if (pom_o !== 1'b1) begin n_fail++; $display("FAIL pom_vwf_hit: got %b want 1", pom_o); end
    vwf = 0; #1;
    n_checks++; if (pom_o !== 1'b0) begin n_fail++; $display("FAIL pom_vwf_off: got %b want 0", pom_o); end
    settle();
  endtask

  task automatic test_stall_reset();
    idle_inputs();
    stall = 1;
    valid = 1; paddr = 56'h7000;
    cycle();
    paddr = 56'h7008; commit = 1;
    cycle();
    valid = 0; commit = 1;
    cycle();
    commit = 0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (req_o !== 1'b0 || no_st_o !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: req %b no_st %b want 0 0", k, req_o, no_st_o); end
      cycle();
    end
    stall = 0;
    for (int k = 0; k < 5 && !req_o; k++) cycle();
    n_checks++; if (req_o !== 1'b1 || addr_o !== 56'h7000) begin n_fail++; $display("FAIL stall_resume: req %b addr %h want 1 7000", req_o, addr_o); end
    stall = 1;
    cycle();
    n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL stall_no_withdraw: got %b want 1", req_o); end
    stall = 0; rst = 1;
    cycle();
    rst = 0;
    n_checks++; if (req_o !== 1'b0 || {addr_o, wdata_o, be_o, size_o} !== '0) begin n_fail++; $display("FAIL rst_mid_req: req %b addr %h", req_o, addr_o); end
    n_checks++; if ({ready_o, commit_ready_o, no_st_o, sbe_o, pom_o} !== 5'b11110) begin n_fail++; $display("FAIL rst_mid_status: got %b want 11110", {ready_o, commit_ready_o, no_st_o, sbe_o, pom_o}); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst    = ($urandom_range(0, 249) == 0);
      flush  = ($urandom_range(0, 19) == 0);
      valid  = (sq.size() < 4) && ($urandom_range(0, 1) == 1);
      commit = (sq.size() > 0) && ($urandom_range(0, 2) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      gnt    = ($urandom_range(0, 1) == 1);
      vwf    = ($urandom_range(0, 1) == 1);
      paddr  = {$urandom, $urandom};
      paddr[11:3] = 9'($urandom_range(0, 7));
      data   = {$urandom, $urandom};
      be     = 8'($urandom);
      size   = 2'($urandom);
      po     = {9'($urandom_range(0, 7)), 3'($urandom)};
      #1;
      n_checks++;
      if (ready_o !== (sq.size() < 4) || commit_ready_o !== (cq.size() < 8)) begin
        n_fail++; $display("FAIL rnd_ready c%0d: ready %b/%b want %b/%b", c, ready_o, commit_ready_o, sq.size() < 4, cq.size() < 8);
      end
      n_checks++;
      if (req_o !== busy) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", c, req_o, busy); end
      n_checks++;
      if (no_st_o !== (cq.size() == 0 && !busy) || sbe_o !== (cq.size() == 0 && !busy && sq.size() == 0)) begin
        n_fail++; $display("FAIL rnd_status c%0d: no_st %b sbe %b", c, no_st_o, sbe_o);
      end
      n_checks++;
      if (pom_o !== exp_pom()) begin n_fail++; $display("FAIL rnd_pom c%0d: got %b want %b", c, pom_o, exp_pom()); end
      if (busy) begin
        n_checks++;
        if (addr_o !== cq[0].paddr || wdata_o !== cq[0].data || be_o !== cq[0].be || size_o !== cq[0].size) begin
          n_fail++; $display("FAIL rnd_fields c%0d: addr %h want %h data %h want %h", c, addr_o, cq[0].paddr, wdata_o, cq[0].data);
        end
      end
      cycle();
    end
    settle();
    n_checks++; if (sbe_o !== 1'b1) begin n_fail++; $display("FAIL rnd_final_empty: got %b want 1", sbe_o); end
  endtask

  initial begin
    idle_inputs();
    busy = 0;
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_back_to_back();
    test_page_offset();
    test_stall_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
